// File: rtl/muldiv_seq.sv
// Sequential 8x8 multiply / divide unit that writes its two result bytes into an external register file.
// Latency: accept at edge 0, one bit per cycle in CALC (cycles 1-8), low write in cycle 9, high write plus done in cycle 10.
// Backpressure: none. start is sampled only in IDLE and ignored otherwise; busy marks the cycles in which start has no effect.
//
// Ports:
//   clk, reset           single clock; asynchronous active-low reset
//   start, op            request (op 0 = MUL, 1 = DIV), sampled in IDLE only
//   a, b                 operands (multiplicand/dividend, multiplier/divisor)
//   dst_lo, dst_hi       register-file addresses for the low and high result bytes
//   busy, done, err      status; done is a one-cycle pulse, err is valid with done
//   reg_w, reg_w_select, reg_w_line   register-file write strobe, address, data
//   zf, cf               result flags, updated with a successful done, otherwise held
//
// Build option: define MULDIV_SEQ_DIV_EN to include the restoring divider.
// Without it, op=1 always completes through the error path.

module muldiv_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] dst_lo,
  input  logic [7:0] dst_hi,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       reg_w,
  output logic [7:0] reg_w_select,
  output logic [7:0] reg_w_line,
  output logic       zf,
  output logic       cf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  // MUL: {partial product high, multiplier shifting out}; DIV: {remainder, dividend/quotient}
  logic [15:0] acc_q, acc_d;
  // Second operand held for the whole calculation: multiplicand for MUL, divisor for DIV
  logic [7:0]  opnd_q, opnd_d;
  logic        op_q, op_d;
  logic [7:0]  dst_lo_q, dst_lo_d;
  logic [7:0]  dst_hi_q, dst_hi_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        reg_w_q, reg_w_d;
  logic [7:0]  reg_w_select_q, reg_w_select_d;
  logic [7:0]  reg_w_line_q, reg_w_line_d;
  logic        zf_q, zf_d;
  logic        cf_q, cf_d;

  // Shift-add step, LSB of the multiplier first. The 9-bit sum keeps the carry,
  // which drops into bit 15 as the whole accumulator shifts right.
  logic [8:0]  mul_sum;
  logic [15:0] mul_step;
  logic [15:0] calc_step;
  // High when an accepted op=1 can actually be computed
  logic        div_ok;

  always_comb begin
    mul_sum  = {1'b0, acc_q[15:8]} + (acc_q[0] ? {1'b0, opnd_q} : 9'd0);
    mul_step = {mul_sum, acc_q[7:1]};
  end

`ifdef MULDIV_SEQ_DIV_EN
  // Restoring step: shift the next dividend bit into the remainder and try the subtraction.
  // The trial remainder is at most 2*divisor-1, so 9 bits hold it and the kept difference fits in 8.
  logic [8:0]  div_rem;
  logic        div_ge;
  logic [7:0]  div_diff;
  logic [15:0] div_step;

  always_comb begin
    div_rem  = {acc_q[15:8], acc_q[7]};
    div_ge   = (div_rem >= {1'b0, opnd_q});
    div_diff = div_rem[7:0] - opnd_q;
    div_step = div_ge ? {div_diff, acc_q[6:0], 1'b1}
                      : {div_rem[7:0], acc_q[6:0], 1'b0};
    calc_step = op_q ? div_step : mul_step;
    div_ok    = (b != 8'd0);
  end
`else
  always_comb begin
    calc_step = mul_step;
    div_ok    = 1'b0;
  end
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    opnd_d         = opnd_q;
    op_d           = op_q;
    dst_lo_d       = dst_lo_q;
    dst_hi_d       = dst_hi_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    reg_w_d        = 1'b0;
    reg_w_select_d = reg_w_select_q;
    reg_w_line_d   = reg_w_line_q;
    zf_d           = zf_q;
    cf_d           = cf_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d     = op;
          dst_lo_d = dst_lo;
          dst_hi_d = dst_hi;
          busy_d   = 1'b1;
          if (op && !div_ok) begin
            // Divide-by-zero or divider not built: complete at once, no writes
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = 3'd7;
            acc_d   = op ? {8'h00, a} : {8'h00, b};
            opnd_d  = op ? b : a;
          end
        end
      end

      CALC: begin
        acc_d = calc_step;
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          // Last step: present the low byte straight from this step's result
          state_d        = WR_LO;
          reg_w_d        = 1'b1;
          reg_w_select_d = dst_lo_q;
          reg_w_line_d   = calc_step[7:0];
        end
      end

      WR_LO: begin
        state_d        = WR_HI;
        reg_w_d        = 1'b1;
        reg_w_select_d = dst_hi_q;
        reg_w_line_d   = acc_q[15:8];
        done_d         = 1'b1;
        zf_d           = op_q ? (acc_q[7:0] == 8'd0) : (acc_q == 16'd0);
        cf_d           = op_q ? 1'b0 : (acc_q[15:8] != 8'd0);
      end

      WR_HI: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      ERR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      acc_q          <= 16'd0;
      opnd_q         <= 8'd0;
      op_q           <= 1'b0;
      dst_lo_q       <= 8'd0;
      dst_hi_q       <= 8'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      reg_w_q        <= 1'b0;
      reg_w_select_q <= 8'd0;
      reg_w_line_q   <= 8'd0;
      zf_q           <= 1'b0;
      cf_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      opnd_q         <= opnd_d;
      op_q           <= op_d;
      dst_lo_q       <= dst_lo_d;
      dst_hi_q       <= dst_hi_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      reg_w_q        <= reg_w_d;
      reg_w_select_q <= reg_w_select_d;
      reg_w_line_q   <= reg_w_line_d;
      zf_q           <= zf_d;
      cf_q           <= cf_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign reg_w        = reg_w_q;
  assign reg_w_select = reg_w_select_q;
  assign reg_w_line   = reg_w_line_q;
  assign zf           = zf_q;
  assign cf           = cf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: scoreboard of expected register writes / completions,
// plus per-operation cycle-timing checks on busy, done and write count.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0, dst_lo = 8'd0, dst_hi = 8'd0;
  logic       busy, done, err, reg_w, zf, cf;
  logic [7:0] reg_w_select, reg_w_line;

`ifdef MULDIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .dst_lo       (dst_lo),
    .dst_hi       (dst_hi),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .reg_w        (reg_w),
    .reg_w_select (reg_w_select),
    .reg_w_line   (reg_w_line),
    .zf           (zf),
    .cf           (cf)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       w;
    logic       d;
    logic       e;
    logic [7:0] sel;
    logic [7:0] line;
    logic       zf;
    logic       cf;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  logic       m_zf = 1'b0;
  logic       m_cf = 1'b0;
  logic [7:0] rf [256];

  // Reference model: push the events one operation must produce
  task automatic expect_op(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                           input logic [7:0] dlo, input logic [7:0] dhi, output bit is_err);
    logic [15:0] p;
    logic [7:0]  lo, hi;
    logic        z, c;
    if (op_i && (!DIV_EN || b_i == 8'd0)) begin
      sb.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, m_zf, m_cf});
      is_err = 1'b1;
    end else begin
      if (op_i) begin
        lo = a_i / b_i;
        hi = a_i % b_i;
        z  = (lo == 8'd0);
        c  = 1'b0;
      end else begin
        p  = 16'(a_i) * 16'(b_i);
        lo = p[7:0];
        hi = p[15:8];
        z  = (p == 16'd0);
        c  = (hi != 8'd0);
      end
      sb.push_back('{1'b1, 1'b0, 1'b0, dlo, lo, 1'b0, 1'b0});
      sb.push_back('{1'b1, 1'b1, 1'b0, dhi, hi, z, c});
      m_zf   = z;
      m_cf   = c;
      is_err = 1'b0;
    end
  endtask

  // Output monitor: every write or completion must match the head of the scoreboard
  always @(negedge clk) begin
    if (reg_w) rf[reg_w_select] = reg_w_line;
    if (reg_w || done) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, reg_w, done}, 32'd0);
      end else begin
        mon_ev = sb.pop_front();
        check("ev_reg_w", 32'(reg_w), 32'(mon_ev.w));
        check("ev_done", 32'(done), 32'(mon_ev.d));
        if (mon_ev.w) begin
          check("ev_sel", 32'(reg_w_select), 32'(mon_ev.sel));
          check("ev_line", 32'(reg_w_line), 32'(mon_ev.line));
        end
        if (mon_ev.d) begin
          check("ev_err", 32'(err), 32'(mon_ev.e));
          check("ev_zf", 32'(zf), 32'(mon_ev.zf));
          check("ev_cf", 32'(cf), 32'(mon_ev.cf));
        end
      end
    end
  end

  // One operation with exact-cycle checks; operands are scrambled right after acceptance
  task automatic do_op(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic [7:0] dlo, input logic [7:0] dhi, input bit glitch);
    bit is_err;
    int done_k, nw, last;
    expect_op(op_i, a_i, b_i, dlo, dhi, is_err);
    @(posedge clk); #1;
    start = 1'b1; op = op_i; a = a_i; b = b_i; dst_lo = dlo; dst_hi = dhi;
    @(posedge clk); #1;
    start = 1'b0; op = ~op_i; a = 8'($urandom); b = 8'($urandom);
    dst_lo = 8'($urandom); dst_hi = 8'($urandom);
    last   = is_err ? 1 : 10;
    done_k = -1;
    nw     = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (done && done_k < 0) done_k = k;
      if (reg_w) nw++;
      check("busy", 32'(busy), 32'(k < last));
      if (glitch && k == 3) start = 1'b1;
      if (glitch && k == 4) start = 1'b0;
    end
    check("done_cycle", 32'(done_k), is_err ? 32'd0 : 32'd9);
    check("write_count", 32'(nw), is_err ? 32'd0 : 32'd2);
  endtask

  initial begin
    bit is_err;
    int dk[3];
    int ndone;

    // Reset state
    #2 reset = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_reg_w", 32'(reg_w), 32'd0);
    check("rst_sel", 32'(reg_w_select), 32'd0);
    check("rst_line", 32'(reg_w_line), 32'd0);
    check("rst_zf_cf", {30'd0, zf, cf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    do_op(1'b0, 8'h0F, 8'h11, 8'h01, 8'h02, 1'b0);
    do_op(1'b0, 8'hFF, 8'hFF, 8'h03, 8'h04, 1'b1);
    // Error completion must leave zf=0, cf=1 from the previous op
    do_op(1'b1, 8'd5, 8'd0, 8'h05, 8'h06, 1'b0);
    if (DIV_EN) do_op(1'b1, 8'd200, 8'd7, 8'h07, 8'h08, 1'b0);
    else        do_op(1'b1, 8'd9, 8'd3, 8'h07, 8'h08, 1'b0);
    do_op(1'b0, 8'h00, 8'h55, 8'h09, 8'h0A, 1'b0);
    do_op(1'b0, 8'h12, 8'h34, 8'h33, 8'h33, 1'b0);
    check("same_dst_hi_wins", 32'(rf[8'h33]), 32'h03);
    for (int i = 0; i < 6; i++)
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)),
            8'($urandom), 8'($urandom), 1'b0);

    // start held high: acceptances 11 edges apart
    for (int i = 0; i < 3; i++) expect_op(1'b0, 8'h21, 8'h13, 8'h40, 8'h41, is_err);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 8'h21; b = 8'h13; dst_lo = 8'h40; dst_hi = 8'h41;
    @(posedge clk); #1;
    ndone = 0;
    dk    = '{-1, -1, -1};
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 3) dk[ndone] = k;
        ndone++;
      end
      if (k == 32) start = 1'b0;
    end
    check("held_done0", 32'(dk[0]), 32'd9);
    check("held_done1", 32'(dk[1]), 32'd20);
    check("held_done2", 32'(dk[2]), 32'd31);
    check("held_count", 32'(ndone), 32'd3);
    repeat (3) @(negedge clk);

    // Give flags a nonzero value, then abort a MUL in its fourth CALC cycle
    do_op(1'b0, 8'hF0, 8'h10, 8'h50, 8'h51, 1'b0);
    expect_op(1'b0, 8'h12, 8'h34, 8'h60, 8'h61, is_err);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34; dst_lo = 8'h60; dst_hi = 8'h61;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 3; k++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_zf_cf", {30'd0, zf, cf}, 32'd0);
    check("abort_strobes", {29'd0, done, err, reg_w}, 32'd0);
    check("abort_sel_line", {16'd0, reg_w_select, reg_w_line}, 32'd0);
    sb.delete();
    m_zf = 1'b0;
    m_cf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || reg_w) ndone++;
    end
    check("abort_no_activity", 32'(ndone), 32'd0);
    do_op(1'b0, 8'd3, 8'd4, 8'h70, 8'h71, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
